// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter that time-shares a 3-to-8 decoder among eight requesters.
// Define DEC_ARB_TIMEOUT_EN to build the hold counter and forced handoff after HOLD_MAX grant cycles.
module decoder_rr_arbiter #(
    parameter int HOLD_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic       e,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic [7:0] grant,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

    state_t     state;
    logic [2:0] ptr;
    logic [2:0] idx;
    logic [2:0] win;
    logic       win_vld;
    logic       start;
    logic       forced;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        win     = 3'd0;
        win_vld = 1'b0;
        // Scan from the far end down so the slot closest to ptr is written last and wins.
        for (int k = 7; k >= 0; k--) begin
            if (req[ptr + 3'(k)]) begin
                win     = ptr + 3'(k);
                win_vld = 1'b1;
            end
        end
    end

    assign start = (state != GRANT) && win_vld;

`ifdef DEC_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] hold_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if (start) begin
            hold_cnt <= CNT_W'(1);
        end else if (state == GRANT && hold_cnt != CNT_W'(HOLD_MAX)) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
        end
    end

    // Only hand off when someone else is actually waiting.
    assign forced = (hold_cnt == CNT_W'(HOLD_MAX)) && req[idx]
                  && |(req & ~(8'd1 << idx));
`else
    logic unused_cfg;
    assign unused_cfg = (HOLD_MAX > 0) ^ (CNT_W > 0);
    assign forced     = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= 3'd0;
            idx   <= 3'd0;
            e     <= 1'b0;
            grant <= 8'h00;
            busy  <= 1'b0;
        end else if (start) begin
            state <= GRANT;
            idx   <= win;
            ptr   <= win + 3'd1;
            e     <= 1'b1;
            grant <= 8'd1 << win;
            busy  <= 1'b1;
        end else begin
            case (state)
                GRANT: begin
                    if (!req[idx] || forced) begin
                        state <= RELEASE;
                        e     <= 1'b0;
                        grant <= 8'h00;
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Select lines track the winner register and stay put through RELEASE and IDLE.
    assign a = idx[2];
    assign b = idx[1];
    assign c = idx[0];

endmodule
